// File: rtl/dyn_out_port_sched.sv
// dyn_out_port_sched: one output port of the dynamic node router.
// Five input ports compete for the link with round-robin head
// arbitration. A granted packet keeps the link until its last body flit
// leaves. Sends are gated by a credit count that the downstream
// neighbour replenishes with yummy returns.
module dyn_out_port_sched #(
   parameter int NUM_IN     = 5,
   parameter int DATA_WIDTH = 64,
   parameter int CREDITS    = 4,
   parameter int LEN_LSB    = 22,
   parameter int LEN_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_IN-1:0]            req_valid,
   input  logic [NUM_IN*DATA_WIDTH-1:0] req_data,
   output logic [NUM_IN-1:0]            req_pop,
   input  logic                         yummyIn,
   output logic [DATA_WIDTH-1:0]        dataOut,
   output logic                         validOut,
   output logic                         busy,
   output logic [2:0]                   grant_id
);

   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [2:0]            owner_q, owner_d;
   logic [LEN_W-1:0]      remaining_q, remaining_d;
   logic [2:0]            rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]         credit_q, credit_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] slot [NUM_IN];
   logic                  can_send;
   logic                  found;
   logic [2:0]            g;
   int                    idx;
   logic                  send;
   logic [2:0]            sel;
   logic [DATA_WIDTH-1:0] sel_flit;

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slot
      assign slot[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Only the registered credit counts; a same-cycle yummy cannot enable a send.
   assign can_send = (credit_q != '0);
   assign sel_flit = slot[sel];

   // Round-robin search: first valid requester starting at rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      g     = '0;
      idx   = 0;
      for (int i = 0; i < NUM_IN; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            g     = 3'(idx);
         end
      end
   end

   // Send decision, wormhole lock tracking and credit accounting.
   always_comb begin
      send        = 1'b0;
      sel         = owner_q;
      state_d     = state_q;
      owner_d     = owner_q;
      remaining_d = remaining_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (can_send && found) begin
               send     = 1'b1;
               sel      = g;
               owner_d  = g;
               rr_ptr_d = (int'(g) == NUM_IN - 1) ? 3'd0 : g + 3'd1;
               if (sel_flit[LEN_LSB +: LEN_W] != '0) begin
                  remaining_d = sel_flit[LEN_LSB +: LEN_W];
                  state_d     = BURST;
               end
            end
         end
         BURST: begin
            // Only the owner may advance; anything else is a hold cycle.
            if (can_send && req_valid[owner_q]) begin
               send        = 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == LEN_W'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      credit_d = credit_q;
      case ({send, yummyIn})
         2'b10:   credit_d = credit_q - 1'b1;
         2'b01:   credit_d = (credit_q == CRED_MAX) ? credit_q : credit_q + 1'b1;
         default: credit_d = credit_q;
      endcase
   end

   // Pop strobe to the input buffers, suppressed while reset is held.
   always_comb begin
      req_pop = '0;
      if (send && rst_n) req_pop[sel] = 1'b1;
   end

   // State, credit and registered link outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         remaining_q <= '0;
         rr_ptr_q    <= '0;
         credit_q    <= CRED_MAX;
         data_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         remaining_q <= remaining_d;
         rr_ptr_q    <= rr_ptr_d;
         credit_q    <= credit_d;
         valid_q     <= send;
         busy_q      <= (state_d == BURST);
         if (send) data_q <= sel_flit;
      end
   end

`ifndef SYNTHESIS
   // Flag a yummy return that would push credit above the buffer depth.
   always_ff @(posedge clk) begin
      if (rst_n && yummyIn && !send && credit_q == CRED_MAX)
         $error("dyn_out_port_sched: yummyIn with credit already at maximum");
   end
`endif

   assign dataOut  = data_q;
   assign validOut = valid_q;
   assign busy     = busy_q;
   assign grant_id = owner_q;

endmodule

// File: tb/tb_dyn_out_port_sched.sv
// Directed bench for dyn_out_port_sched: each task drives one scenario
// and compares the pop strobe and link outputs against hand-derived values.
module tb_dyn_out_port_sched;

   localparam int NI = 5;
   localparam int DW = 64;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NI-1:0]    req_valid;
   logic [NI*DW-1:0] req_data;
   logic [NI-1:0]    req_pop;
   logic             yummyIn;
   logic [DW-1:0]    dataOut;
   logic             validOut;
   logic             busy;
   logic [2:0]       grant_id;

   int checks   = 0;
   int failures = 0;

   dyn_out_port_sched #(
      .NUM_IN(NI), .DATA_WIDTH(DW), .CREDITS(4), .LEN_LSB(22), .LEN_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_pop(req_pop), .yummyIn(yummyIn), .dataOut(dataOut),
      .validOut(validOut), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Flit with a tag replicated in every byte and the given length field.
   function automatic logic [63:0] mk(input logic [7:0] tag, input logic [7:0] len);
      logic [63:0] r;
      r = {8{tag}};
      r[29:22] = len;
      return r;
   endfunction

   task automatic set_slot(input int p, input logic [63:0] f);
      req_data[p*DW +: DW] = f;
   endtask

   // Idle cycles that hand credits back without any request.
   task automatic give_yummy(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_valid = '0;
         yummyIn   = 1'b1;
      end
      @(negedge clk);
      yummyIn = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      yummyIn   = 1'b0;
      req_valid = '1;
      for (int i = 0; i < NI; i++) set_slot(i, mk(8'hEE, 8'd0));
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_pop !== 5'b0) begin failures++; $display("FAIL reset_pop got=%b want=00000", req_pop); end
      checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", validOut); end
      checks++; if (dataOut !== 64'h0) begin failures++; $display("FAIL reset_data got=%h want=0", dataOut); end
      checks++; if (busy !== 1'b0 || grant_id !== 3'd0) begin failures++; $display("FAIL reset_busy_gid got=%b/%0d want=0/0", busy, grant_id); end
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   task automatic test_single_p();
      @(negedge clk);
      req_valid = 5'b10000;
      set_slot(4, mk(8'hC4, 8'd0));
      #1;
      checks++; if (req_pop !== 5'b10000) begin failures++; $display("FAIL single_pop got=%b want=10000", req_pop); end
      @(posedge clk); #1;
      checks++; if (validOut !== 1'b1 || dataOut !== mk(8'hC4, 8'd0)) begin failures++; $display("FAIL single_out got=%b/%h want=1/%h", validOut, dataOut, mk(8'hC4, 8'd0)); end
      checks++; if (grant_id !== 3'd4 || busy !== 1'b0) begin failures++; $display("FAIL single_gid got=%0d/%b want=4/0", grant_id, busy); end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (req_pop !== 5'b0) begin failures++; $display("FAIL single_nopop got=%b want=00000", req_pop); end
      @(posedge clk); #1;
      checks++; if (validOut !== 1'b0 || dataOut !== mk(8'hC4, 8'd0)) begin failures++; $display("FAIL single_hold got=%b/%h want=0/%h", validOut, dataOut, mk(8'hC4, 8'd0)); end
      give_yummy(1);
   endtask

   task automatic test_rr_fair();
      logic [4:0] ep;
      int         e;
      for (int i = 0; i < NI; i++) set_slot(i, mk(8'hA0 + 8'(i), 8'd0));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = '1;
         yummyIn   = (c != 0);
         e  = c % NI;
         ep = '0;
         ep[e] = 1'b1;
         #1;
         checks++; if (req_pop !== ep) begin failures++; $display("FAIL rr_pop c=%0d got=%b want=%b", c, req_pop, ep); end
         @(posedge clk); #1;
         checks++; if (validOut !== 1'b1 || dataOut !== mk(8'hA0 + 8'(e), 8'd0) || grant_id !== 3'(e)) begin
            failures++; $display("FAIL rr_out c=%0d got=%b/%h/%0d want=1/%h/%0d", c, validOut, dataOut, grant_id, mk(8'hA0 + 8'(e), 8'd0), e);
         end
      end
      give_yummy(1);
   endtask

   task automatic test_burst_ne();
      logic [63:0] nf [3];
      logic [63:0] ef [3];
      logic [5:0]  bz;
      logic [4:0]  ep;
      logic [63:0] ed;
      nf = '{mk(8'h10, 8'd2), mk(8'h11, 8'h11), mk(8'h12, 8'h12)};
      ef = '{mk(8'h20, 8'd2), mk(8'h21, 8'h21), mk(8'h22, 8'h22)};
      bz = 6'b011011;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 5'b00011;
         yummyIn   = (c != 0);
         set_slot(0, (c < 3) ? nf[c] : mk(8'h13, 8'd0));
         set_slot(1, (c < 3) ? ef[0] : ef[c-3]);
         ep = (c < 3) ? 5'b00001 : 5'b00010;
         ed = (c < 3) ? nf[c] : ef[c-3];
         #1;
         checks++; if (req_pop !== ep) begin failures++; $display("FAIL ne_pop c=%0d got=%b want=%b", c, req_pop, ep); end
         @(posedge clk); #1;
         checks++; if (validOut !== 1'b1 || dataOut !== ed) begin failures++; $display("FAIL ne_out c=%0d got=%b/%h want=1/%h", c, validOut, dataOut, ed); end
         checks++; if (busy !== bz[c] || grant_id !== ((c < 3) ? 3'd0 : 3'd1)) begin
            failures++; $display("FAIL ne_busy c=%0d got=%b/%0d want=%b/%0d", c, busy, grant_id, bz[c], (c < 3) ? 0 : 1);
         end
      end
      give_yummy(1);
   endtask

   task automatic test_credit_stall();
      logic [63:0] wf [9];
      logic [13:0] yum;
      logic [13:0] snd;
      logic [4:0]  ep;
      int          k;
      wf[0] = mk(8'h30, 8'd8);
      for (int i = 1; i < 9; i++) wf[i] = mk(8'h30 + 8'(i), 8'h30 + 8'(i));
      yum = 14'b11111001000000;
      snd = 14'b11110010001111;
      k = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         req_valid = 5'b01000;
         yummyIn   = yum[c];
         set_slot(3, wf[k]);
         ep = snd[c] ? 5'b01000 : 5'b00000;
         #1;
         checks++; if (req_pop !== ep) begin failures++; $display("FAIL stall_pop c=%0d got=%b want=%b", c, req_pop, ep); end
         @(posedge clk); #1;
         if (snd[c]) k++;
         checks++; if (validOut !== snd[c] || dataOut !== wf[k-1]) begin
            failures++; $display("FAIL stall_out c=%0d got=%b/%h want=%b/%h", c, validOut, dataOut, snd[c], wf[k-1]);
         end
         checks++; if (busy !== (c < 13)) begin failures++; $display("FAIL stall_busy c=%0d got=%b want=%b", c, busy, c < 13); end
      end
      give_yummy(3);
   endtask

   task automatic test_owner_bubble();
      logic [4:0]  vv [7];
      logic [4:0]  pp [7];
      logic [63:0] es [7];
      logic [63:0] dd [7];
      logic [6:0]  vo;
      logic [6:0]  bz;
      logic [6:0]  g1;
      logic [63:0] e0, e1, e2, n0;
      e0 = mk(8'h40, 8'd2); e1 = mk(8'h41, 8'h41); e2 = mk(8'h42, 8'h42); n0 = mk(8'h50, 8'd0);
      vv = '{5'b00010, 5'b00001, 5'b00001, 5'b00001, 5'b00011, 5'b00011, 5'b00001};
      pp = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00001};
      es = '{e0, e1, e1, e1, e1, e2, e2};
      dd = '{e0, e0, e0, e0, e1, e2, n0};
      vo = 7'b1110001;
      bz = 7'b0011111;
      g1 = 7'b0111111;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         req_valid = vv[c];
         yummyIn   = 1'b0;
         set_slot(0, n0);
         set_slot(1, es[c]);
         #1;
         checks++; if (req_pop !== pp[c]) begin failures++; $display("FAIL bubble_pop c=%0d got=%b want=%b", c, req_pop, pp[c]); end
         @(posedge clk); #1;
         checks++; if (validOut !== vo[c] || dataOut !== dd[c]) begin
            failures++; $display("FAIL bubble_out c=%0d got=%b/%h want=%b/%h", c, validOut, dataOut, vo[c], dd[c]);
         end
         checks++; if (busy !== bz[c] || grant_id !== {2'b00, g1[c]}) begin
            failures++; $display("FAIL bubble_busy c=%0d got=%b/%0d want=%b/%0d", c, busy, grant_id, bz[c], g1[c]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [4:0] ep;
      give_yummy(4);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 5'b00100;
         set_slot(2, (c == 0) ? mk(8'h60, 8'd5) : mk(8'h60 + 8'(c), 8'hFF));
         #1;
         checks++; if (req_pop !== 5'b00100) begin failures++; $display("FAIL mid_pop c=%0d got=%b want=00100", c, req_pop); end
         @(posedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (req_pop !== 5'b0) begin failures++; $display("FAIL mid_rst_pop got=%b want=00000", req_pop); end
      checks++; if (validOut !== 1'b0 || dataOut !== 64'h0 || busy !== 1'b0 || grant_id !== 3'd0) begin
         failures++; $display("FAIL mid_rst_out got=%b/%h/%b/%0d want=0/0/0/0", validOut, dataOut, busy, grant_id);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;
      for (int i = 0; i < NI; i++) set_slot(i, mk(8'h70 + 8'(i), 8'd0));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = '1;
         ep = '0;
         if (c < 4) ep[c] = 1'b1;
         #1;
         checks++; if (req_pop !== ep) begin failures++; $display("FAIL post_rst_pop c=%0d got=%b want=%b", c, req_pop, ep); end
         @(posedge clk); #1;
         checks++; if (validOut !== (c < 4)) begin failures++; $display("FAIL post_rst_valid c=%0d got=%b want=%b", c, validOut, c < 4); end
         if (c < 4) begin
            checks++; if (dataOut !== mk(8'h70 + 8'(c), 8'd0)) begin failures++; $display("FAIL post_rst_data c=%0d got=%h want=%h", c, dataOut, mk(8'h70 + 8'(c), 8'd0)); end
         end
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   initial begin
      req_data = '0;
      test_reset();
      test_single_p();
      test_rr_fair();
      test_burst_ne();
      test_credit_stall();
      test_owner_bubble();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dyn_out_port_sched.md
# dyn_out_port_sched

Per-output-port scheduler for the dynamic node router. Arbitrates five input ports (N, E, S, W, P) onto one output link using round-robin selection and wormhole locking. A granted packet keeps the output until its last body flit leaves. Flow is gated by a credit counter fed from the downstream neighbour's yummy returns, and the block drives the registered dataOut/validOut pair of that link.

## Interface
- NUM_IN, 5, number of requesting input ports; index 0..4 = N, E, S, W, P
- DATA_WIDTH, 64, flit width
- CREDITS, 4, downstream buffer depth; initial and maximum credit count
- LEN_LSB, 22, LSB of the payload-length field in a head flit
- LEN_W, 8, width of the payload-length field (number of body flits following the head)
- clk  in  1  router clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_IN  input buffer i has a flit at its head that is routed to this output
- req_data  in  NUM_IN*DATA_WIDTH  head flits of the input buffers; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_pop  out  NUM_IN  one-hot, combinational; input buffer i dequeues its head flit this cycle
- yummyIn  in  1  downstream consumed one flit; returns one credit
- dataOut  out  DATA_WIDTH  registered flit to the link
- validOut  out  1  registered; dataOut is valid
- busy  out  1  registered; high while a multi-flit packet holds the output
- grant_id  out  3  registered index of the current or most recent owner

## Operation
- State register has two states, IDLE and BURST. Other state: owner[2:0], remaining[LEN_W-1:0], rr_ptr[2:0], credit[$clog2(CREDITS+1)-1:0].
- can_send = (credit != 0). Only the registered credit value is used; a yummyIn in the same cycle does not enable a send.
- IDLE: if can_send and any req_valid, select the first asserted index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_IN. That selection is g.
  - Assert req_pop[g]. Register req_data slice g into dataOut. Set validOut=1 and owner=g.
  - Set rr_ptr = (g+1) mod NUM_IN. rr_ptr advances on every head grant.
  - len = req_data[g][LEN_LSB +: LEN_W]. If len==0, stay in IDLE (single-flit packet; back-to-back grants are allowed). Otherwise set remaining=len and go to BURST.
- BURST: only owner may send. If req_valid[owner] and can_send:
  - assert req_pop[owner] and forward its flit
  - decrement remaining
  - if remaining==1 at the time of the send, go to IDLE
  - otherwise (owner not valid, or credit 0) hold: no pop, validOut=0, state unchanged, no other port is served.
- Cycles with no send: validOut=0 and dataOut holds its previous value.
- Credit update:
  - credit_next = credit − send + yummyIn
  - send and yummyIn together leave credit unchanged
  - yummyIn at credit==CREDITS is an upstream protocol error: credit saturates at CREDITS, plus a simulation-only $error
- busy = (state_next==BURST), registered.
- req_pop is never asserted when rst_n is low, and never for an index whose req_valid is low.
- Body flits are not inspected; a length field in a body flit is ignored.

## Timing
- Reset values (asynchronous): state=IDLE, credit=CREDITS, rr_ptr=0, owner=0, remaining=0, dataOut=0, validOut=0, busy=0, grant_id=0.
- req_pop is asserted in the same cycle as the decision. dataOut/validOut appear on the next rising edge (1-cycle latency from req_pop).
- Sustained throughput is 1 flit/cycle while credit>0.
- With CREDITS=4 and no yummy returns, at most 4 flits are sent, then the block stalls.
- A packet of len L occupies the output for at least L+1 send cycles. The next head grant can occur in the cycle after the last body flit is popped.
- Reset asserted mid-packet aborts immediately to IDLE with credits restored. Flits already handed off or partially sent are the neighbour's/reset domain's concern.

## Test plan
- Reset release, then req_valid[P] with a head flit len=0 and credit 4: req_pop=5'b10000 in the same cycle; next cycle validOut=1, dataOut equals that flit, credit=3, rr_ptr=0.
- N and E both valid, each holding a head flit with len=2, rr_ptr=0: N gets 3 consecutive pops while E sees no pop; then E is granted; validOut is high for 6 consecutive cycles; busy is high during N's 2 body-flit cycles.
- Credit stall: no yummyIn, W sends an 8-body-flit packet. After 4 flits validOut=0 and the block stays in BURST. One yummyIn pulse leads to exactly one more flit, sent one cycle after the credit increments.
- Round-robin fairness: all 5 ports continuously valid with single-flit packets. Grant order is 0,1,2,3,4,0,…, with yummyIn returned each cycle so credit stays ≥1.
- Owner bubble: during E's BURST, req_valid[E] drops for 3 cycles while N stays valid. There are no pops, validOut=0, and N is not granted. E resumes, then N is granted after E's last flit.
- rst_n pulsed low mid-BURST (remaining=3, credit=1): outputs return to reset values immediately, credit=4, and the first grant after release goes to index 0 when it is valid.
